// File: rtl/pe_run_sequencer.sv
// Per-tile ap_start scheduler for a row of NUM_PE pass-through PE tiles.
// Latency: accept edge ends cycle 0; tile i is high on cycles 1+i*STAGGER .. i*STAGGER+run_len; done on E+1.
// Backpressure: cmd_ready high only in IDLE; pause freezes the schedule, halt aborts the run.
module pe_run_sequencer #(
   parameter int NUM_PE    = 4,
   parameter int STAGGER   = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CNT_WIDTH-1:0] cmd_run_len,
   input  logic [NUM_PE-1:0]    cmd_mask,
   input  logic                 pause,
   input  logic                 halt,
   output logic [NUM_PE-1:0]    ap_start,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic [CNT_WIDTH-1:0] active_cycles
);

   // Schedule position is wide enough that skew + run_len can never wrap it.
   localparam int SW = CNT_WIDTH + 9;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        pos_q, pos_d;
   logic [SW-1:0]        end_q, end_d;
   logic [CNT_WIDTH-1:0] len_q, len_d;
   logic [NUM_PE-1:0]    mask_q, mask_d;
   logic [NUM_PE-1:0]    ap_q, ap_d;
   logic [CNT_WIDTH-1:0] act_q, act_d;
   logic                 done_q, done_d;
   logic                 aborted_q, aborted_d;
   logic                 ready_q, busy_q;

   // Tiles whose window covers schedule position p (positions start at 1).
   function automatic logic [NUM_PE-1:0] window(input logic [SW-1:0]        p,
                                                input logic [NUM_PE-1:0]    m,
                                                input logic [CNT_WIDTH-1:0] len);
      logic [SW-1:0] off;
      window = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         off       = SW'(i * STAGGER);
         window[i] = m[i] && (p > off) && (p <= off + SW'(len));
      end
   endfunction

   // Next-state and next-output logic; the position only advances on unpaused edges.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      end_d     = end_q;
      len_d     = len_q;
      mask_d    = mask_q;
      act_d     = act_q;
      aborted_d = aborted_q;
      ap_d      = '0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               len_d     = cmd_run_len;
               mask_d    = cmd_mask;
               end_d     = SW'((NUM_PE - 1) * STAGGER) + SW'(cmd_run_len);
               pos_d     = SW'(1);
               act_d     = '0;
               aborted_d = 1'b0;
               if (cmd_run_len == '0 || cmd_mask == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ACTIVE;
                  ap_d    = window(SW'(1), cmd_mask, cmd_run_len);
               end
            end
         end
         S_ACTIVE: begin
            if (!pause && act_q != '1) act_d = act_q + 1'b1;
            if (halt) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (pause) begin
               // hold position; every tile idles this cycle
            end else if (pos_q == end_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               pos_d = pos_q + SW'(1);
               ap_d  = window(pos_q + SW'(1), mask_q, len_q);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; synchronous reset returns everything to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pos_q     <= '0;
         end_q     <= '0;
         len_q     <= '0;
         mask_q    <= '0;
         ap_q      <= '0;
         act_q     <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         end_q     <= end_d;
         len_q     <= len_d;
         mask_q    <= mask_d;
         ap_q      <= ap_d;
         act_q     <= act_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         ready_q   <= (state_d == S_IDLE);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   assign ap_start      = ap_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign active_cycles = act_q;
   assign cmd_ready     = ready_q;

endmodule

// File: tb/tb_pe_run_sequencer.sv
// Bench for pe_run_sequencer: cycle-level reference model plus directed runs.
// Latency: compares every cycle on the falling edge.
// Backpressure: exercises pause, halt, mid-run reset and held cmd_valid.
module tb_pe_run_sequencer;

   localparam int NP = 4;
   localparam int ST = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_run_len = '0;
   logic [NP-1:0] cmd_mask = '0;
   logic          pause = 1'b0;
   logic          halt = 1'b0;
   logic [NP-1:0] ap_start;
   logic          busy, done, aborted;
   logic [CW-1:0] active_cycles;

   int checks = 0;
   int failures = 0;

   pe_run_sequencer #(.NUM_PE(NP), .STAGGER(ST), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_run_len(cmd_run_len), .cmd_mask(cmd_mask), .pause(pause), .halt(halt),
      .ap_start(ap_start), .busy(busy), .done(done), .aborted(aborted),
      .active_cycles(active_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the run as (cycle since accept, paused cycles so far); the effective
   // schedule position is their difference.
   int            ph = 0;          // 0 idle, 1 active, 2 done
   int            m_cyc, m_pn, m_len, m_end;
   logic [NP-1:0] m_mask;
   logic          m_ok = 1'b0;
   logic [NP-1:0] e_ap;
   logic          e_busy, e_done, e_ab, e_rdy;
   logic [CW-1:0] e_act;

   function automatic logic [NP-1:0] exp_win(input int eff, input logic [NP-1:0] m, input int len);
      logic [NP-1:0] r;
      r = '0;
      for (int i = 0; i < NP; i++)
         r[i] = m[i] && eff >= 1 + i * ST && eff <= i * ST + len;
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         ph = 0; e_ap = '0; e_busy = 0; e_done = 0; e_ab = 0; e_act = '0; e_rdy = 1;
         m_ok = 1'b1;
      end else if (m_ok) begin
         e_done = 0;
         e_ap   = '0;
         case (ph)
            0: if (cmd_valid) begin
               m_len = int'(cmd_run_len); m_mask = cmd_mask;
               m_cyc = 1; m_pn = 0; e_ab = 0; e_act = '0;
               m_end = (NP - 1) * ST + m_len;
               if (m_len == 0 || m_mask == '0) begin
                  ph = 2; e_done = 1;
               end else begin
                  ph = 1; e_ap = exp_win(1, m_mask, m_len);
               end
            end
            1: begin
               if (!pause && e_act != {CW{1'b1}}) e_act = e_act + 1'b1;
               if (halt) begin
                  ph = 2; e_done = 1; e_ab = 1;
               end else if (!pause && m_cyc - m_pn == m_end) begin
                  ph = 2; e_done = 1;
               end else begin
                  m_cyc++;
                  if (pause) m_pn++;
                  else e_ap = exp_win(m_cyc - m_pn, m_mask, m_len);
               end
            end
            default: ph = 0;
         endcase
         e_busy = (ph != 0);
         e_rdy  = (ph == 0);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("ap_start", ap_start, e_ap);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("aborted", aborted, e_ab);
         chk("active_cycles", active_cycles, e_act);
         chk("cmd_ready", cmd_ready, e_rdy);
      end
   end

   // ---------------- directed runs ----------------
   int   f[NP], l[NP], c[NP];
   int   dcyc, rcyc, dact;
   logic dab;

   // Accepts one command, then steps ncyc cycles recording per-tile windows.
   // pause is high during cycles plo..phi, halt during hc, reset during rc.
   task automatic run(input logic [CW-1:0] len, input logic [NP-1:0] mask,
                      input int plo, input int phi, input int hc, input int rc, input int ncyc);
      for (int i = 0; i < NP; i++) begin f[i] = -1; l[i] = -1; c[i] = 0; end
      dcyc = -1; rcyc = -1; dact = -1; dab = 1'b0;
      chk("accept_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_run_len = len; cmd_mask = mask;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         for (int i = 0; i < NP; i++)
            if (ap_start[i]) begin
               if (f[i] < 0) f[i] = k;
               l[i] = k; c[i]++;
            end
         if (done && dcyc < 0) begin dcyc = k; dab = aborted; dact = int'(active_cycles); end
         if (cmd_ready && rcyc < 0) rcyc = k;
         pause = (k >= plo && k <= phi);
         halt  = (k == hc);
         reset = (k == rc);
         @(negedge clk);
      end
      pause = 1'b0; halt = 1'b0; reset = 1'b0;
   endtask

   task automatic chk_tiles(input string t, input int ef[NP], input int el[NP], input int ec[NP]);
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("%s_first%0d", t, i), f[i], ef[i]);
         chk($sformatf("%s_last%0d", t, i), l[i], el[i]);
         chk($sformatf("%s_count%0d", t, i), c[i], ec[i]);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ap", ap_start, 0);
      chk("rst_act", active_cycles, 0);

      // 1: full mask
      run(4'd5, 4'b1111, -1, -1, -1, -1, 14);
      chk_tiles("t1", '{1, 3, 5, 7}, '{5, 7, 9, 11}, '{5, 5, 5, 5});
      chk("t1_done", dcyc, 12); chk("t1_act", dact, 11);
      chk("t1_ready", rcyc, 13); chk("t1_ab", dab, 0);

      // 2: partial mask
      run(4'd5, 4'b0101, -1, -1, -1, -1, 14);
      chk_tiles("t2", '{1, -1, 5, -1}, '{5, -1, 9, -1}, '{5, 0, 5, 0});
      chk("t2_done", dcyc, 12);

      // 3: pause during cycles 4-5
      run(4'd5, 4'b1111, 4, 5, -1, -1, 16);
      chk_tiles("t3", '{1, 3, 7, 9}, '{7, 9, 11, 13}, '{5, 5, 5, 5});
      chk("t3_done", dcyc, 14); chk("t3_act", dact, 11); chk("t3_ready", rcyc, 15);

      // 4: halt during cycle 6
      run(4'd5, 4'b1111, -1, -1, 6, -1, 10);
      chk_tiles("t4", '{1, 3, 5, -1}, '{5, 6, 6, -1}, '{5, 4, 2, 0});
      chk("t4_done", dcyc, 7); chk("t4_ab", dab, 1); chk("t4_ready", rcyc, 8);
      chk("t4_act", dact, 6);
      chk("t4_ab_hold", aborted, 1);

      // 5: degenerate commands
      run(4'd0, 4'b1111, -1, -1, -1, -1, 3);
      chk("t5a_done", dcyc, 1); chk("t5a_ab", dab, 0); chk("t5a_ready", rcyc, 2);
      chk("t5a_cnt", c[0] + c[1] + c[2] + c[3], 0);
      run(4'd5, 4'b0000, -1, -1, -1, -1, 3);
      chk("t5b_done", dcyc, 1); chk("t5b_ready", rcyc, 2);
      chk("t5b_cnt", c[0] + c[1] + c[2] + c[3], 0);

      // 6: reset during cycle 4, re-accept, then cmd_valid held through a run
      run(4'd5, 4'b1111, -1, -1, -1, 4, 4);
      chk("t6_ap", ap_start, 0); chk("t6_busy", busy, 0); chk("t6_done", done, 0);
      chk("t6_ab", aborted, 0); chk("t6_act", active_cycles, 0); chk("t6_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_run_len = 4'd5; cmd_mask = 4'b1111;
      @(negedge clk);
      chk("t6_busy_after", busy, 1);
      cmd_run_len = 4'd3; cmd_mask = 4'b0001;
      dcyc = -1; rcyc = -1;
      for (int k = 1; k <= 14; k++) begin
         if (done && dcyc < 0) dcyc = k;
         if (cmd_ready && rcyc < 0) rcyc = k;
         if (k < 14) @(negedge clk);
      end
      chk("t6_held_done", dcyc, 12); chk("t6_held_ready", rcyc, 13);
      cmd_valid = 1'b0;
      chk("t6_reaccept_busy", busy, 1);
      repeat (12) @(negedge clk);

      // 7: active_cycles saturation
      run(4'd15, 4'b1111, -1, -1, -1, -1, 24);
      chk("t7_done", dcyc, 22); chk("t7_act", dact, 15);
      chk("t7_first3", f[3], 7); chk("t7_last3", l[3], 21); chk("t7_count3", c[3], 15);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
